// File: rtl/eth_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | eth_pkg : shared Ethernet packet-type, transmit-kind and ethertype defs     |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
package eth_pkg;

    typedef enum logic [1:0] {
        PKT_NONE     = 2'd0,
        PKT_ARP_REQ  = 2'd1,
        PKT_ARP_RESP = 2'd2,
        PKT_UDP      = 2'd3
    } pkt_type_e;

    typedef enum logic {
        TX_ARP = 1'b0,
        TX_UDP = 1'b1
    } tx_kind_e;

    localparam logic [15:0] c_ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] c_ETHERTYPE_ARP  = 16'h0806;

endpackage
`default_nettype wire

// File: rtl/eth_arp_pend_buf.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | eth_arp_pend_buf : one-deep pending ARP reply buffer with overwrite count   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module eth_arp_pend_buf
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] self_ip,
    input  logic [1:0]  pkt_type,
    input  logic [47:0] sha,
    input  logic [31:0] spa,
    input  logic [31:0] tpa,
    input  logic        consume,
    output logic        pend,
    output logic [47:0] pend_sha,
    output logic [31:0] pend_spa,
    output logic [7:0]  drop_cnt
);

    logic w_capture;

    assign w_capture = (pkt_type == PKT_ARP_REQ) && (tpa == self_ip);

    // A capture in the same cycle as a consume refills the buffer without counting a drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= 1'b0;
            pend_sha <= '0;
            pend_spa <= '0;
            drop_cnt <= '0;
        end else begin
            if (w_capture) begin
                pend     <= 1'b1;
                pend_sha <= sha;
                pend_spa <= spa;
                if (pend && !consume && (drop_cnt != 8'hFF)) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end else if (consume) begin
                pend <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/eth_tx_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | eth_tx_sched : round-robin scheduler of the Ethernet TX engine (ARP / UDP)  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module eth_tx_sched
    import eth_pkg::*;
#(
    parameter int IFG_CYCLES = 12,
    parameter int TX_TIMEOUT = 4096,
    parameter int CNT_W      = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_self_ip,
    input  logic [1:0]  i_pkt_type,
    input  logic [47:0] i_SHA,
    input  logic [31:0] i_SPA,
    input  logic [31:0] i_TPA,
    input  logic        i_udp_req,
    output logic        o_udp_gnt,
    output logic        o_tx_start,
    output logic        o_tx_kind,
    output logic [47:0] o_arp_tha,
    output logic [31:0] o_arp_tpa,
    input  logic        i_tx_done,
    output logic        o_arp_pend,
    output logic [7:0]  o_arp_drop,
    output logic        o_timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_GAP   = 2'd3
    } state_e;

    state_e           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    tx_kind_e         r_last, w_last_next;
    tx_kind_e         r_kind, w_kind_next;
    logic             r_udp_gnt, w_udp_gnt_next;
    logic [47:0]      r_tha, w_tha_next;
    logic [31:0]      r_tpa, w_tpa_next;
    logic             r_timeout, w_timeout_next;

    logic             w_consume;
    logic             w_pend;
    logic [47:0]      w_pend_sha;
    logic [31:0]      w_pend_spa;
    logic             w_end_frame;
    logic             w_expire;

    eth_arp_pend_buf u_pend_buf (
        .clk      (clk),
        .rst      (rst),
        .self_ip  (i_self_ip),
        .pkt_type (i_pkt_type),
        .sha      (i_SHA),
        .spa      (i_SPA),
        .tpa      (i_TPA),
        .consume  (w_consume),
        .pend     (w_pend),
        .pend_sha (w_pend_sha),
        .pend_spa (w_pend_spa),
        .drop_cnt (o_arp_drop)
    );

    // Counter is cleared leaving START, so it reaches TX_TIMEOUT-1 on the edge that flags the timeout.
    assign w_expire    = (r_cnt == CNT_W'(TX_TIMEOUT - 2));
    assign w_end_frame = i_tx_done || w_expire;

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_last_next    = r_last;
        w_kind_next    = r_kind;
        w_udp_gnt_next = r_udp_gnt;
        w_tha_next     = r_tha;
        w_tpa_next     = r_tpa;
        w_timeout_next = r_timeout;
        w_consume      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pend && (!i_udp_req || (r_last == TX_UDP))) begin
                    w_consume    = 1'b1;
                    w_tha_next   = w_pend_sha;
                    w_tpa_next   = w_pend_spa;
                    w_kind_next  = TX_ARP;
                    w_state_next = S_START;
                end else if (i_udp_req) begin
                    w_udp_gnt_next = 1'b1;
                    w_kind_next    = TX_UDP;
                    w_state_next   = S_START;
                end
            end
            S_START: begin
                w_cnt_next   = '0;
                w_state_next = S_BUSY;
            end
            S_BUSY: begin
                if (w_end_frame) begin
                    if (!i_tx_done) begin
                        w_timeout_next = 1'b1;
                    end
                    w_udp_gnt_next = 1'b0;
                    w_last_next    = r_kind;
                    w_cnt_next     = '0;
                    w_state_next   = S_GAP;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (r_cnt == CNT_W'(IFG_CYCLES - 1)) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_last    <= TX_UDP;
            r_kind    <= TX_ARP;
            r_udp_gnt <= 1'b0;
            r_tha     <= '0;
            r_tpa     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_last    <= w_last_next;
            r_kind    <= w_kind_next;
            r_udp_gnt <= w_udp_gnt_next;
            r_tha     <= w_tha_next;
            r_tpa     <= w_tpa_next;
            r_timeout <= w_timeout_next;
        end
    end

    assign o_tx_start = (r_state == S_START);
    assign o_tx_kind  = r_kind;
    assign o_udp_gnt  = r_udp_gnt;
    assign o_arp_tha  = r_tha;
    assign o_arp_tpa  = r_tpa;
    assign o_arp_pend = w_pend;
    assign o_timeout  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_eth_tx_sched : vector table, directed sequences and random vs. model     |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_eth_tx_sched;

    localparam int          IFG      = 12;
    localparam int          TMO      = 64;
    localparam logic [31:0] SELF_IP  = 32'hC0A8010A;
    localparam logic [31:0] OTHER_IP = 32'hC0A8010B;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] self_ip = SELF_IP;
    logic [1:0]  pkt_type = 2'd0;
    logic [47:0] sha = '0;
    logic [31:0] spa = '0;
    logic [31:0] tpa = '0;
    logic        udp_req = 1'b0;
    logic        tx_done = 1'b0;
    logic        udp_gnt, tx_start, tx_kind, arp_pend, timeout;
    logic [47:0] arp_tha;
    logic [31:0] arp_tpa;
    logic [7:0]  arp_drop;

    eth_tx_sched #(.IFG_CYCLES(IFG), .TX_TIMEOUT(TMO), .CNT_W(13)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_self_ip  (self_ip),
        .i_pkt_type (pkt_type),
        .i_SHA      (sha),
        .i_SPA      (spa),
        .i_TPA      (tpa),
        .i_udp_req  (udp_req),
        .o_udp_gnt  (udp_gnt),
        .o_tx_start (tx_start),
        .o_tx_kind  (tx_kind),
        .o_arp_tha  (arp_tha),
        .o_arp_tpa  (arp_tpa),
        .i_tx_done  (tx_done),
        .o_arp_pend (arp_pend),
        .o_arp_drop (arp_drop),
        .o_timeout  (timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_done;
    int start_seen;

    // Reference model: frame timing kept as cycle numbers, pending reply as plain variables.
    bit          m_pend, m_kind, m_gnt, m_timeout, m_last_udp, m_start, m_inflight;
    logic [47:0] m_sha, m_tha;
    logic [31:0] m_spa, m_tpa;
    logic [7:0]  m_drop;
    int          m_start_cyc, m_free_at;

    typedef struct {
        logic [1:0]  pkt;
        bit          hit;
        logic [47:0] s;
        bit          done;
        bit          e_start;
        bit          e_kind;
        bit          e_pend;
        logic [7:0]  e_drop;
        logic [47:0] e_tha;
    } vec_t;
    vec_t vt [9];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_kind = 0; m_gnt = 0; m_timeout = 0; m_last_udp = 1;
        m_start = 0; m_inflight = 0; m_sha = '0; m_tha = '0; m_spa = '0;
        m_tpa = '0; m_drop = '0; m_start_cyc = 0; m_free_at = 0; cyc = 0;
    endtask

    task automatic model_eval();
        bit consume;
        consume = 0;
        m_start = 0;
        if (!m_inflight) begin
            if (cyc >= m_free_at && (m_pend || udp_req)) begin
                if (m_pend && (!udp_req || m_last_udp)) begin
                    consume = 1; m_tha = m_sha; m_tpa = m_spa; m_kind = 0;
                end else begin
                    m_kind = 1; m_gnt = 1;
                end
                m_inflight = 1; m_start_cyc = cyc + 1; m_start = 1;
            end
        end else if (cyc > m_start_cyc) begin
            if (tx_done || (cyc - m_start_cyc == TMO - 1)) begin
                if (!tx_done) m_timeout = 1;
                m_inflight = 0; m_gnt = 0; m_last_udp = m_kind;
                m_free_at = cyc + 1 + IFG;
            end
        end
        if (pkt_type == 2'd1 && tpa == self_ip) begin
            if (m_pend && !consume && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
            m_pend = 1; m_sha = sha; m_spa = spa;
        end else if (consume) begin
            m_pend = 0;
        end
    endtask

    task automatic step();
        model_eval();
        @(posedge clk);
        #1;
        cyc++;
        check($sformatf("model@%0d", cyc),
              {tx_start, tx_kind, udp_gnt, arp_pend, timeout, arp_drop, arp_tha, arp_tpa},
              {m_start, m_kind, m_gnt, m_pend, m_timeout, m_drop, m_tha, m_tpa});
    endtask

    task automatic do_reset();
        pkt_type = 2'd0; sha = '0; spa = '0; tpa = '0; udp_req = 0; tx_done = 0;
        rst = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    task automatic pulse_arp(input logic [47:0] s, input logic [31:0] p, input bit hit);
        pkt_type = 2'd1; sha = s; spa = p; tpa = hit ? SELF_IP : OTHER_IP;
        step();
        pkt_type = 2'd0;
    endtask

    task automatic finish_frame(input int len);
        for (int i = 0; i < len - 1; i++) step();
        tx_done = 1;
        last_done = cyc;
        step();
        tx_done = 0;
    endtask

    task automatic wait_start(input int budget, input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (tx_start) seen = 1;
        end
        start_seen = cyc;
        check(name, seen, 1);
    endtask

    initial begin
        int tcyc;
        int tx_left;
        int r;
        vt[0] = '{2'd1, 1'b0, 48'hDEADBEEF0001, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 48'h0};
        vt[1] = '{2'd2, 1'b1, 48'hDEADBEEF0002, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 48'h0};
        vt[2] = '{2'd3, 1'b1, 48'hDEADBEEF0003, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 48'h0};
        vt[3] = '{2'd1, 1'b1, 48'h001122334455, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 48'h0};
        vt[4] = '{2'd0, 1'b0, 48'h0,            1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 48'h001122334455};
        vt[5] = '{2'd0, 1'b0, 48'h0,            1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 48'h001122334455};
        vt[6] = '{2'd1, 1'b1, 48'h0B0B0B0B0B0B, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 48'h001122334455};
        vt[7] = '{2'd1, 1'b1, 48'h0C0C0C0C0C0C, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 48'h001122334455};
        vt[8] = '{2'd0, 1'b0, 48'h0,            1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 48'h001122334455};

        // Reset values, then round-robin between ARP and UDP
        do_reset();
        check("reset_outputs", {tx_start, tx_kind, udp_gnt, arp_pend, timeout, arp_drop, arp_tha, arp_tpa}, 0);
        pulse_arp(48'hA1A2A3A4A5A6, 32'h0A000001, 1);
        check("alt_pend", arp_pend, 1);
        udp_req = 1;
        wait_start(4, "alt1_start");
        check("alt1_latency", start_seen, 2);
        check("alt1_kind", tx_kind, 0);
        check("alt1_gnt", udp_gnt, 0);
        check("alt1_tha", arp_tha, 48'hA1A2A3A4A5A6);
        finish_frame(5);
        wait_start(IFG + 10, "alt2_start");
        check("alt2_kind_gnt", {tx_kind, udp_gnt}, 2'b11);
        check("alt2_gap", (start_seen - last_done >= IFG + 1), 1);
        pulse_arp(48'hB1B2B3B4B5B6, 32'h0A000002, 1);
        step(); step();
        check("alt2_gnt_held", udp_gnt, 1);
        finish_frame(4);
        check("alt2_gnt_drop", udp_gnt, 0);
        wait_start(IFG + 10, "alt3_start");
        check("alt3_kind", tx_kind, 0);
        check("alt3_tha", arp_tha, 48'hB1B2B3B4B5B6);
        finish_frame(3);
        wait_start(IFG + 10, "alt4_start");
        check("alt4_kind", tx_kind, 1);
        udp_req = 0;
        finish_frame(3);
        check("alt4_gnt_drop", udp_gnt, 0);

        // Vector table: capture filter, overwrite counting, done ignored in START
        do_reset();
        for (int i = 0; i < 9; i++) begin
            pkt_type = vt[i].pkt; sha = vt[i].s; spa = 32'h0A0000F0 + i;
            tpa = vt[i].hit ? SELF_IP : OTHER_IP; tx_done = vt[i].done;
            if (vt[i].done) last_done = cyc;
            step();
            check($sformatf("vec%0d", i), {tx_start, tx_kind, arp_pend, udp_gnt, arp_drop, arp_tha},
                  {vt[i].e_start, vt[i].e_kind, vt[i].e_pend, 1'b0, vt[i].e_drop, vt[i].e_tha});
        end
        pkt_type = 2'd0; tx_done = 0;
        wait_start(IFG + 10, "tbl_reply");
        check("tbl_reply_tha", {tx_kind, arp_tha}, {1'b0, 48'h0C0C0C0C0C0C});
        check("tbl_gap", (start_seen - last_done >= IFG + 1), 1);
        finish_frame(6);

        // Three ARP requests during a long UDP frame
        do_reset();
        udp_req = 1;
        wait_start(4, "long_start");
        check("long_kind", tx_kind, 1);
        udp_req = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 5 || i == 15 || i == 25) begin
                pkt_type = 2'd1; tpa = SELF_IP; sha = 48'h020000000000 + i; spa = 32'h0A000100 + i;
            end else begin
                pkt_type = 2'd0;
            end
            tx_done = (i == 49);
            if (tx_done) last_done = cyc;
            step();
            if (i == 30) check("long_gnt_held", udp_gnt, 1);
        end
        pkt_type = 2'd0; tx_done = 0;
        check("long_drop", {arp_pend, arp_drop}, {1'b1, 8'd2});
        wait_start(IFG + 10, "long_reply");
        check("long_reply_tha", {tx_kind, arp_tha, arp_tpa}, {1'b0, 48'h020000000019, 32'h0A000119});
        check("long_gap", (start_seen - last_done >= IFG + 1), 1);
        finish_frame(4);

        // Withheld done: timeout exactly TMO clocks after the start strobe
        udp_req = 1;
        wait_start(IFG + 10, "tmo_start");
        tcyc = start_seen;
        udp_req = 0;
        for (int i = 0; i < 100 && !timeout; i++) step();
        check("tmo_seen", timeout, 1);
        check("tmo_delay", cyc - tcyc, TMO);
        check("tmo_gnt_drop", udp_gnt, 0);
        pulse_arp(48'hD1D2D3D4D5D6, 32'h0A000004, 1);
        wait_start(IFG + 10, "tmo_recover");
        check("tmo_recover_tha", {tx_kind, arp_tha}, {1'b0, 48'hD1D2D3D4D5D6});
        finish_frame(3);

        // Reset in BUSY with a reply pending and timeout sticky
        udp_req = 1;
        wait_start(IFG + 10, "rst_start");
        step(); step();
        pulse_arp(48'hE1E2E3E4E5E6, 32'h0A000005, 1);
        check("rst_pre", {arp_pend, timeout, udp_gnt}, 3'b111);
        rst = 1;
        #2;
        check("rst_async", {tx_start, tx_kind, udp_gnt, arp_pend, timeout, arp_drop, arp_tha, arp_tpa}, 0);
        @(posedge clk);
        #1;
        check("rst_edge", {tx_start, tx_kind, udp_gnt, arp_pend, timeout, arp_drop, arp_tha, arp_tpa}, 0);
        udp_req = 0;
        rst = 0;
        model_reset();
        for (int i = 0; i < 20; i++) step();
        check("rst_no_pend", {arp_pend, tx_start}, 2'b00);

        // Random traffic against the model; the bench plays the transmitter
        do_reset();
        tx_left = 0;
        for (int i = 0; i < 3000; i++) begin
            tx_done = 0;
            if (tx_left > 0) begin
                tx_left--;
                if (tx_left == 0) tx_done = 1;
            end else if ($urandom_range(0, 49) == 0) begin
                tx_done = 1;
            end
            if (tx_start) tx_left = ($urandom_range(0, 11) == 0) ? 200 : $urandom_range(1, 40);
            r = $urandom_range(0, 7);
            pkt_type = (r == 0 || r == 1) ? 2'd1 : (r == 2) ? 2'($urandom_range(2, 3)) : 2'd0;
            tpa = (r == 1) ? OTHER_IP : SELF_IP;
            sha = {16'($urandom), 32'($urandom)};
            spa = 32'($urandom);
            if ($urandom_range(0, 15) == 0) udp_req = ~udp_req;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
